heartbeat_gen: RTL and testbench

- Processor-side heartbeat transmitter. Each redundant flight computer instantiates one; its 3-bit hb output drives one heartbeat input of the fault detection unit, where a watchdog checks it.
- Produces a Gray-code heartbeat that advances only while software keeps kicking it. Freezes the heartbeat on kick timeout or injected fault.
- Honours the FDU power-on-reset request and reports whether the FDU has selected this unit as prime.

---
 rtl/heartbeat_gen.sv | 126 ++++++++++++
 tb/tb_heartbeat_gen.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/heartbeat_gen.sv
// Processor-side heartbeat transmitter: kick-gated Gray-code heartbeat with
// stall on kick timeout or injected fault, FDU POR hold and prime reporting.
module heartbeat_gen #(
    parameter int unsigned BEAT_PERIOD  = 5000000,
    parameter int unsigned KICK_TIMEOUT = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       kick,
    input  logic       fault_inject,
    input  logic       por_in,
    input  logic [1:0] prime_in,
    input  logic       unit_id,
    output logic [2:0] hb,
    output logic       is_prime,
    output logic       sw_reset,
    output logic [1:0] status
);

    localparam int unsigned BW = $clog2(BEAT_PERIOD) + 1;
    localparam int unsigned KW = $clog2(KICK_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RUN     = 2'b01,
        S_STALLED = 2'b10,
        S_PORHOLD = 2'b11
    } state_t;

    state_t          state;
    state_t          state_d;
    logic            por_q1;
    logic            por_s;
    logic [BW-1:0]   beat_cnt;
    logic [KW-1:0]   kick_cnt;
    logic            beat_wrap;
    logic            kick_expired;
    logic            run_stay;
    logic            kick_live;
    logic            prime_match;

    // Next Gray code in the 000,001,011,010,110,111,101,100 ring
    function automatic logic [2:0] gray_next(input logic [2:0] g);
        logic [2:0] n;
        case (g)
            3'b000:  n = 3'b001;
            3'b001:  n = 3'b011;
            3'b011:  n = 3'b010;
            3'b010:  n = 3'b110;
            3'b110:  n = 3'b111;
            3'b111:  n = 3'b101;
            3'b101:  n = 3'b100;
            default: n = 3'b000;
        endcase
        return n;
    endfunction

    // POR request synchronizer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            por_q1 <= 1'b0;
            por_s  <= 1'b0;
        end else begin
            por_q1 <= por_in;
            por_s  <= por_q1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_d;
    end

    // Next-state logic and counter controls
    always_comb begin
        state_d      = state;
        beat_wrap    = (beat_cnt == BW'(BEAT_PERIOD - 1));
        kick_expired = (kick_cnt == KW'(KICK_TIMEOUT - 1));
        prime_match  = (!unit_id && prime_in == 2'b01) || (unit_id && prime_in == 2'b10);
        if (por_s) begin
            state_d = S_PORHOLD;
        end else begin
            case (state)
                S_PORHOLD: state_d = S_IDLE;
                S_IDLE:    if (kick && !fault_inject) state_d = S_RUN;
                S_RUN: begin
                    if (fault_inject)               state_d = S_STALLED;
                    else if (!kick && kick_expired) state_d = S_STALLED;
                end
                S_STALLED: if (kick && !fault_inject) state_d = S_RUN;
                default:   state_d = state;
            endcase
        end
        run_stay  = (state == S_RUN) && (state_d == S_RUN);
        // Any change of state other than RUN<->STALLED restarts the kick watchdog
        kick_live = (state == S_RUN || state == S_STALLED) &&
                    (state_d == S_RUN || state_d == S_STALLED);
    end

    // Counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt <= '0;
            kick_cnt <= '0;
            hb       <= 3'b000;
            sw_reset <= 1'b0;
            is_prime <= 1'b0;
        end else begin
            if (run_stay) beat_cnt <= beat_wrap ? '0 : beat_cnt + BW'(1);
            else          beat_cnt <= '0;

            if (!kick_live || kick)                     kick_cnt <= '0;
            else if (kick_cnt != KW'(KICK_TIMEOUT))     kick_cnt <= kick_cnt + KW'(1);

            if (state_d == S_PORHOLD)     hb <= 3'b000;
            else if (run_stay && beat_wrap) hb <= gray_next(hb);

            sw_reset <= (state_d == S_PORHOLD);
            is_prime <= (state_d != S_PORHOLD) && prime_match;
        end
    end

    assign status = state;

endmodule

// File: tb/tb_heartbeat_gen.sv
// Directed self-checking bench for heartbeat_gen with BEAT_PERIOD=4, KICK_TIMEOUT=20.
module tb_heartbeat_gen;

    logic       clk;
    logic       reset;
    logic       kick;
    logic       fault_inject;
    logic       por_in;
    logic [1:0] prime_in;
    logic       unit_id;
    logic [2:0] hb;
    logic       is_prime;
    logic       sw_reset;
    logic [1:0] status;

    int checks   = 0;
    int failures = 0;
    int m_beat   = 0;
    int m_idx    = 0;

    heartbeat_gen #(.BEAT_PERIOD(4), .KICK_TIMEOUT(20)) dut (
        .clk(clk), .reset(reset), .kick(kick), .fault_inject(fault_inject),
        .por_in(por_in), .prime_in(prime_in), .unit_id(unit_id),
        .hb(hb), .is_prime(is_prime), .sw_reset(sw_reset), .status(status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] gray_of(input int i);
        case (i % 8)
            0: return 3'b000;
            1: return 3'b001;
            2: return 3'b011;
            3: return 3'b010;
            4: return 3'b110;
            5: return 3'b111;
            6: return 3'b101;
            default: return 3'b100;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference beat model for one clock spent in RUN
    task automatic model_step();
        if (m_beat == 3) begin
            m_beat = 0;
            m_idx  = m_idx + 1;
        end else begin
            m_beat = m_beat + 1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; kick = 1'b0; fault_inject = 1'b0; por_in = 1'b0;
        prime_in = 2'b01; unit_id = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({hb, is_prime, sw_reset, status} !== 7'b0) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got hb=%b prime=%b swr=%b st=%b want all 0",
                         i, hb, is_prime, sw_reset, status);
            end
        end
        reset = 1'b1;
        prime_in = 2'b00;
    endtask

    task automatic test_run_sequence();
        tick(); tick();
        checks++;
        if (status !== 2'b00) begin
            failures++; $display("FAIL idle_before_kick got st=%b want 00", status);
        end
        kick = 1'b1; tick(); kick = 1'b0;
        m_beat = 0; m_idx = 0;
        checks++;
        if (status !== 2'b01 || hb !== 3'b000) begin
            failures++; $display("FAIL enter_run got st=%b hb=%b want 01/000", status, hb);
        end
        for (int n = 1; n <= 32; n++) begin
            if (n == 16) kick = 1'b1;
            tick();
            kick = 1'b0;
            model_step();
            checks++;
            if (hb !== gray_of(m_idx) || status !== 2'b01) begin
                failures++;
                $display("FAIL gray_seq n=%0d got hb=%b st=%b want hb=%b st=01", n, hb, status, gray_of(m_idx));
            end
        end
        checks++;
        if (hb !== 3'b000) begin
            failures++; $display("FAIL gray_wrap got hb=%b want 000", hb);
        end
    endtask

    task automatic test_kick_timeout();
        int bad = 0;
        for (int k = 0; k < 20; k++) begin
            for (int c = 0; c < 10; c++) begin
                kick = (c == 0);
                tick();
                model_step();
                if (status !== 2'b01 || hb !== gray_of(m_idx)) bad++;
            end
        end
        kick = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL kicked_run bad_cycles=%0d want 0", bad);
        end
        // 9 edges already elapsed since the last kick; 10 more stay in RUN
        for (int c = 0; c < 10; c++) begin
            tick();
            model_step();
        end
        checks++;
        if (status !== 2'b01) begin
            failures++; $display("FAIL pre_timeout got st=%b want 01", status);
        end
        tick();
        checks++;
        if (status !== 2'b10 || hb !== gray_of(m_idx)) begin
            failures++;
            $display("FAIL timeout_stall got st=%b hb=%b want 10/%b", status, hb, gray_of(m_idx));
        end
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (status !== 2'b10 || hb !== gray_of(m_idx)) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL stall_frozen bad_cycles=%0d want 0", bad);
        end
    endtask

    task automatic test_fault();
        int guard = 0;
        kick = 1'b1; tick(); kick = 1'b0;
        m_beat = 0;
        checks++;
        if (status !== 2'b01 || hb !== gray_of(m_idx)) begin
            failures++; $display("FAIL resume_no_jump got st=%b hb=%b want 01/%b", status, hb, gray_of(m_idx));
        end
        while (!(gray_of(m_idx) == 3'b011 && m_beat == 0) && guard < 64) begin
            kick = (guard % 8 == 7);
            tick();
            kick = 1'b0;
            model_step();
            guard++;
        end
        checks++;
        if (hb !== 3'b011 || status !== 2'b01) begin
            failures++; $display("FAIL reach_011 got hb=%b st=%b want 011/01", hb, status);
        end
        fault_inject = 1'b1; tick();
        checks++;
        if (status !== 2'b10 || hb !== 3'b011) begin
            failures++; $display("FAIL fault_stall got st=%b hb=%b want 10/011", status, hb);
        end
        kick = 1'b1; tick(); kick = 1'b0;
        checks++;
        if (status !== 2'b10) begin
            failures++; $display("FAIL fault_beats_kick got st=%b want 10", status);
        end
        fault_inject = 1'b0; tick();
        kick = 1'b1; tick(); kick = 1'b0;
        checks++;
        if (status !== 2'b01 || hb !== 3'b011) begin
            failures++; $display("FAIL fault_resume got st=%b hb=%b want 01/011", status, hb);
        end
        tick(); tick(); tick();
        checks++;
        if (hb !== 3'b011) begin
            failures++; $display("FAIL resume_early got hb=%b want 011", hb);
        end
        tick();
        checks++;
        if (hb !== 3'b010) begin
            failures++; $display("FAIL resume_step got hb=%b want 010", hb);
        end
    endtask

    task automatic test_por();
        prime_in = 2'b01; unit_id = 1'b0;
        kick = 1'b1; tick(); kick = 1'b0;
        checks++;
        if (is_prime !== 1'b1 || status !== 2'b01) begin
            failures++; $display("FAIL prime_in_run got prime=%b st=%b want 1/01", is_prime, status);
        end
        por_in = 1'b1;
        tick(); tick();
        checks++;
        if (status !== 2'b01 || sw_reset !== 1'b0) begin
            failures++; $display("FAIL por_sync_delay got st=%b swr=%b want 01/0", status, sw_reset);
        end
        tick();
        checks++;
        if (status !== 2'b11 || sw_reset !== 1'b1 || hb !== 3'b000 || is_prime !== 1'b0) begin
            failures++;
            $display("FAIL por_enter got st=%b swr=%b hb=%b prime=%b want 11/1/000/0", status, sw_reset, hb, is_prime);
        end
        kick = 1'b1;
        for (int c = 0; c < 7; c++) tick();
        kick = 1'b0;
        checks++;
        if (status !== 2'b11 || sw_reset !== 1'b1) begin
            failures++; $display("FAIL por_hold got st=%b swr=%b want 11/1", status, sw_reset);
        end
        por_in = 1'b0;
        tick(); tick();
        checks++;
        if (status !== 2'b11) begin
            failures++; $display("FAIL por_exit_delay got st=%b want 11", status);
        end
        tick();
        checks++;
        if (status !== 2'b00 || sw_reset !== 1'b0 || hb !== 3'b000 || is_prime !== 1'b1) begin
            failures++;
            $display("FAIL por_exit got st=%b swr=%b hb=%b prime=%b want 00/0/000/1", status, sw_reset, hb, is_prime);
        end
        for (int c = 0; c < 5; c++) tick();
        checks++;
        if (status !== 2'b00) begin
            failures++; $display("FAIL idle_needs_kick got st=%b want 00", status);
        end
    endtask

    task automatic test_prime();
        logic exp_prev;
        logic exp;
        exp_prev = is_prime;
        for (int u = 0; u < 2; u++) begin
            for (int p = 0; p < 4; p++) begin
                unit_id  = u[0];
                prime_in = p[1:0];
                exp = (u == 0 && p == 1) || (u == 1 && p == 2);
                #1;
                checks++;
                if (is_prime !== exp_prev) begin
                    failures++; $display("FAIL prime_latency u=%0d p=%0d got %b want %b", u, p, is_prime, exp_prev);
                end
                tick();
                checks++;
                if (is_prime !== exp) begin
                    failures++; $display("FAIL prime_decode u=%0d p=%0d got %b want %b", u, p, is_prime, exp);
                end
                exp_prev = exp;
            end
        end
        prime_in = 2'b00; unit_id = 1'b0;
    endtask

    task automatic test_async_reset();
        prime_in = 2'b10; unit_id = 1'b1;
        kick = 1'b1; tick(); kick = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        checks++;
        if (status !== 2'b01 || hb !== 3'b001 || is_prime !== 1'b1) begin
            failures++; $display("FAIL pre_async_run got st=%b hb=%b prime=%b want 01/001/1", status, hb, is_prime);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({hb, is_prime, sw_reset, status} !== 7'b0) begin
            failures++;
            $display("FAIL async_reset_run got hb=%b prime=%b swr=%b st=%b want all 0", hb, is_prime, sw_reset, status);
        end
        tick(); reset = 1'b1;
        por_in = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (status !== 2'b11 || sw_reset !== 1'b1) begin
            failures++; $display("FAIL pre_async_por got st=%b swr=%b want 11/1", status, sw_reset);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({hb, is_prime, sw_reset, status} !== 7'b0) begin
            failures++;
            $display("FAIL async_reset_por got hb=%b prime=%b swr=%b st=%b want all 0", hb, is_prime, sw_reset, status);
        end
        por_in = 1'b0;
        tick(); reset = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        kick = 1'b1; tick(); kick = 1'b0;
        for (int c = 0; c < 19; c++) tick();
        kick = 1'b1; tick(); kick = 1'b0;
        checks++;
        if (status !== 2'b01) begin
            failures++; $display("FAIL kick_at_timeout got st=%b want 01", status);
        end
        for (int c = 0; c < 19; c++) tick();
        checks++;
        if (status !== 2'b01) begin
            failures++; $display("FAIL post_kick_run got st=%b want 01", status);
        end
        tick();
        checks++;
        if (status !== 2'b10) begin
            failures++; $display("FAIL post_kick_timeout got st=%b want 10", status);
        end
    endtask

    initial begin
        test_reset();
        test_run_sequence();
        test_kick_timeout();
        test_fault();
        test_por();
        test_prime();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
